rgb_stream_src: RTL and testbench

- Video stream source that generates a complete raster (active, front porch, sync, back porch) and a selectable test pattern.
- Drives the r/g/b/hsync/vsync/vde valid/ready stream consumed by the RGB processing pipeline. It is the transmitting end of that interface.
- Honours downstream backpressure beat-by-beat, so the raster never advances without a handshake.
- Used as on-chip stimulus and as a bring-up source in place of the camera/HDMI input.

---
 rtl/rgb_stream_src.sv | 165 ++++++++++++++++
 tb/tb_rgb_stream_src.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb_stream_src.sv
// Raster video source: walks a full H/V timing grid and emits one registered
// RGB/sync beat per valid/ready handshake, with a choice of four test patterns.
module rgb_stream_src #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] pattern_i,
  output logic [7:0] r_o,
  output logic [7:0] g_o,
  output logic [7:0] b_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       vde_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [7:0] frame_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are at least 8 bits so the gradient pattern can always take [7:0].
  localparam int HW    = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int VW    = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [BW-1:0] BAR_LAST  = BW'(BAR_W - 1);

  logic [HW-1:0] hCnt_q, hCnt_d;
  logic [VW-1:0] vCnt_q, vCnt_d;
  logic [7:0]    frameCnt_q, frameCnt_d;
  logic [1:0]    pat_q, pat_d;
  logic [7:0]    flat_q, flat_d;
  logic [2:0]    barIdx_q, barIdx_d;
  logic [BW-1:0] barPos_q, barPos_d;
  logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, vde_q, vde_d;
  logic          valid_q;
  logic          load, hWrap, vWrap, frameStart;

  // Everything below describes the beat that would be loaded on this edge.
  always_comb begin
    load       = !valid_q || ready_i;
    hWrap      = (hCnt_q == H_LAST);
    vWrap      = (vCnt_q == V_LAST);
    hCnt_d     = '0;
    vCnt_d     = '0;
    frameCnt_d = frameCnt_q;
    if (valid_q) begin
      hCnt_d = hWrap ? '0 : hCnt_q + HW'(1);
      vCnt_d = hWrap ? (vWrap ? '0 : vCnt_q + VW'(1)) : vCnt_q;
      if (hWrap && vWrap) begin
        frameCnt_d = frameCnt_q + 8'd1;
      end
    end

    frameStart = (hCnt_d == '0) && (vCnt_d == '0);
    pat_d      = frameStart ? pattern_i  : pat_q;
    flat_d     = frameStart ? frameCnt_d : flat_q;

    // Bar index tracks hx / BAR_W incrementally instead of dividing.
    barIdx_d = barIdx_q;
    barPos_d = barPos_q + BW'(1);
    if (hCnt_d == '0) begin
      barIdx_d = '0;
      barPos_d = '0;
    end else if (barPos_q == BAR_LAST) begin
      barIdx_d = barIdx_q + 3'd1;
      barPos_d = '0;
    end

    vde_d   = (hCnt_d < H_ACT) && (vCnt_d < V_ACT);
    hsync_d = ((hCnt_d >= HS_FIRST) && (hCnt_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((vCnt_d >= VS_FIRST) && (vCnt_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;

    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (vde_d) begin
      case (pat_d)
        2'd0: begin
          r_d = {8{~barIdx_d[1]}};
          g_d = {8{~barIdx_d[2]}};
          b_d = {8{~barIdx_d[0]}};
        end
        2'd1: begin
          r_d = hCnt_d[7:0];
          g_d = vCnt_d[7:0];
          b_d = hCnt_d[7:0] ^ vCnt_d[7:0];
        end
        2'd2: begin
          r_d = {8{hCnt_d[3] ^ vCnt_d[3]}};
          g_d = r_d;
          b_d = r_d;
        end
        default: begin
          r_d = flat_d;
          g_d = flat_d;
          b_d = flat_d;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hCnt_q     <= '0;
      vCnt_q     <= '0;
      frameCnt_q <= '0;
      pat_q      <= '0;
      flat_q     <= '0;
      barIdx_q   <= '0;
      barPos_q   <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      vde_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else if (load) begin
      hCnt_q     <= hCnt_d;
      vCnt_q     <= vCnt_d;
      frameCnt_q <= frameCnt_d;
      pat_q      <= pat_d;
      flat_q     <= flat_d;
      barIdx_q   <= barIdx_d;
      barPos_q   <= barPos_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      vde_q      <= vde_d;
      valid_q    <= 1'b1;
    end
  end

  assign r_o         = r_q;
  assign g_o         = g_q;
  assign b_o         = b_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign vde_o       = vde_q;
  assign valid_o     = valid_q;
  assign frame_cnt_o = frameCnt_q;

endmodule

// File: tb/tb_rgb_stream_src.sv
// Bench for rgb_stream_src on a tiny 12x7 raster: a frame-level model predicts
// every beat, with literal spot checks at the interesting beats.
module tb_rgb_stream_src;
  localparam int   HA = 8, HF = 1, HS = 2, HB = 1;
  localparam int   VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam logic SP = 1'b0;

  logic       clk_i = 1'b0;
  logic       rst_i, ready_i;
  logic [1:0] pattern_i;
  logic [7:0] r_o, g_o, b_o, frame_cnt_o;
  logic       hsync_o, vsync_o, vde_o, valid_o;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;
  int mValid = 0, mh = 0, mv = 0, mFrame = 0, mPat = 0, mFlat = 0;
  int vsLow;

  rgb_stream_src #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(SP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pattern_i(pattern_i),
    .r_o(r_o), .g_o(g_o), .b_o(b_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .vde_o(vde_o),
    .valid_o(valid_o), .ready_i(ready_i), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected {valid, vde, hsync, vsync, r, g, b, frame} for one raster position.
  function automatic logic [35:0] expBeat(int valid, int h, int v, int pat, int flat, int frame);
    logic       vde, hs, vs;
    logic [7:0] r, g, b;
    int         k;
    if (valid == 0) return {1'b0, 1'b0, ~SP, ~SP, 24'h0, 8'(frame)};
    vde = (h < HA) && (v < VA);
    hs  = (h >= HA + HF && h < HA + HF + HS) ? SP : ~SP;
    vs  = (v >= VA + VF && v < VA + VF + VS) ? SP : ~SP;
    r = 8'h00; g = 8'h00; b = 8'h00;
    if (vde) begin
      case (pat)
        0: begin
          k = h / (HA / 8);
          r = (k == 0 || k == 1 || k == 4 || k == 5) ? 8'hFF : 8'h00;
          g = (k <= 3) ? 8'hFF : 8'h00;
          b = (k % 2 == 0) ? 8'hFF : 8'h00;
        end
        1: begin
          r = 8'(h % 256);
          g = 8'(v % 256);
          b = r ^ g;
        end
        2: begin
          r = (((h / 8) % 2) != ((v / 8) % 2)) ? 8'hFF : 8'h00;
          g = r;
          b = r;
        end
        default: begin
          r = 8'(flat);
          g = r;
          b = r;
        end
      endcase
    end
    return {1'b1, vde, hs, vs, r, g, b, 8'(frame)};
  endfunction

  // Raster position model: moves one beat per accepted handshake.
  always @(posedge clk_i) begin
    if (rst_i) begin
      checking = 1'b1;
      mValid = 0; mh = 0; mv = 0; mFrame = 0; mPat = 0; mFlat = 0;
    end else if (mValid == 0) begin
      mValid = 1; mh = 0; mv = 0;
      mPat = int'(pattern_i);
      mFlat = mFrame;
    end else if (ready_i) begin
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = mv + 1;
        if (mv == VT) begin
          mv = 0;
          mFrame = (mFrame + 1) % 256;
        end
      end
      if (mh == 0 && mv == 0) begin
        mPat = int'(pattern_i);
        mFlat = mFrame;
      end
    end
  end

  always @(negedge clk_i) begin
    logic [35:0] act, exp;
    if (checking) begin
      exp = expBeat(mValid, mh, mv, mPat, mFlat, mFrame);
      act = {valid_o, vde_o, hsync_o, vsync_o, r_o, g_o, b_o, frame_cnt_o};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("[TB] FAIL beat h=%0d v=%0d: actual {v,de,hs,vs,rgb,frm}=%h required=%h",
                 mh, mv, act, exp);
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic rdy, input logic [1:0] pat);
    rst_i     = rst;
    ready_i   = rdy;
    pattern_i = pat;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic waitBeat(input int h, input int v, input int limit);
    int n = 0;
    while (!(mValid == 1 && mh == h && mv == v) && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitBeat(%0d,%0d): timed out after %0d cycles", h, v, limit);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b1, 1'b1, 2'd0);
    repeat (2) @(negedge clk_i);
    checkOutput("reset valid", 32'(valid_o), 32'd0);
    checkOutput("reset syncs", {30'd0, hsync_o, vsync_o}, 32'h3);
    checkOutput("reset rgb", {8'd0, r_o, g_o, b_o}, 32'h0);

    applyStimulus(1'b0, 1'b1, 2'd0);
    @(negedge clk_i);
    vsLow = 0;
    for (int i = 0; i < HT * VT; i++) begin
      if (i == 0) begin
        checkOutput("first valid/vde", {30'd0, valid_o, vde_o}, 32'h3);
        checkOutput("first rgb", {8'd0, r_o, g_o, b_o}, 32'hFFFFFF);
        checkOutput("first syncs", {30'd0, hsync_o, vsync_o}, 32'h3);
      end
      if (i == 5) checkOutput("bar h5 rgb", {8'd0, r_o, g_o, b_o}, 32'hFF0000);
      if (i == 7) checkOutput("bar h7 rgb", {8'd0, r_o, g_o, b_o}, 32'h000000);
      if (i == 9 || i == 10)
        checkOutput("hsync beat", {7'd0, hsync_o, vde_o, r_o, g_o, b_o}, 32'h0);
      if (i == HT * VT - 1) checkOutput("frame before wrap", 32'(frame_cnt_o), 32'd0);
      if (vsync_o == 1'b0) vsLow++;
      @(negedge clk_i);
    end
    checkOutput("frame after wrap", 32'(frame_cnt_o), 32'd1);
    checkOutput("vsync low beats", 32'(vsLow), 32'd12);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 2'd0);
      @(negedge clk_i);
    end
    applyStimulus(1'b0, 1'b1, 2'd0);

    waitBeat(3, 2, 200);
    applyStimulus(1'b0, 1'b1, 2'd1);
    @(negedge clk_i);
    waitBeat(3, 2, 200);
    checkOutput("gradient (3,2)", {8'd0, r_o, g_o, b_o}, 32'h030201);

    waitBeat(6, 3, 200);
    applyStimulus(1'b1, 1'b1, 2'd0);
    @(negedge clk_i);
    checkOutput("midframe reset", {4'd0, valid_o, vde_o, hsync_o, vsync_o, r_o, g_o, b_o},
                32'h0300_0000);
    checkOutput("midframe reset frame", 32'(frame_cnt_o), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'd0);
    @(negedge clk_i);
    checkOutput("restart rgb", {8'd0, r_o, g_o, b_o}, 32'hFFFFFF);
    checkOutput("restart frame", 32'(frame_cnt_o), 32'd0);

    applyStimulus(1'b0, 1'b1, 2'd3);
    @(negedge clk_i);
    waitBeat(0, 0, 200);
    checkOutput("flat frame 1", {8'd0, r_o, g_o, b_o}, 32'h010101);
    while (!(mFrame == 255 && mh == 0 && mv == 0) && checks < 100000)
      @(negedge clk_i);
    checkOutput("flat frame 255", {frame_cnt_o, r_o, g_o, b_o}, 32'hFFFFFFFF);
    repeat (HT * VT) @(negedge clk_i);
    checkOutput("flat frame wrap", {frame_cnt_o, r_o, g_o, b_o}, 32'h00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
